demux12_reg: RTL

Registered 1-to-12 demultiplexer, the write-side counterpart of the 12-input datapath selector. A single 32-bit source is routed to one of twelve held destination registers, chosen by a 4-bit select and qualified by a write enable. A one-hot strobe marks which destination was updated. A sticky error flag catches out-of-range selects, and a saturating counter tracks accepted writes for debug and verification.

---
 rtl/demux12_reg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/demux12_reg.sv
// Registered 1-to-12 demultiplexer: one 32-bit source is written into one of twelve held
// destination registers, with a one-hot strobe, a sticky range error and a saturating write count.

module demux12_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (reset)      q_o <= '0;
    else if (clr_i) q_o <= '0;
    else if (we_i)  q_o <= d_i;
  end
endmodule

module demux12_reg #(
  parameter int LARGURA = 32,
  parameter int N_DEST  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  input  logic [3:0]         selecao,
  input  logic               escreve,
  input  logic               limpa,
  output logic [LARGURA-1:0] primeiro,
  output logic [LARGURA-1:0] segundo,
  output logic [LARGURA-1:0] terceiro,
  output logic [LARGURA-1:0] quarto,
  output logic [LARGURA-1:0] quinto,
  output logic [LARGURA-1:0] sexto,
  output logic [LARGURA-1:0] setimo,
  output logic [LARGURA-1:0] oitavo,
  output logic [LARGURA-1:0] nono,
  output logic [LARGURA-1:0] decimo,
  output logic [LARGURA-1:0] onze,
  output logic [LARGURA-1:0] doze,
  output logic [N_DEST-1:0]  pulso,
  output logic [3:0]         ultimo,
  output logic               erro,
  output logic [7:0]         contagem
);
  logic [N_DEST-1:0][LARGURA-1:0] dest_q;
  logic [N_DEST-1:0]              sel_oh, we_vec;
  logic                           sel_ok, acc;
  logic [N_DEST-1:0]              pulso_q, pulso_d;
  logic [3:0]                     ultimo_q, ultimo_d;
  logic                           erro_q, erro_d;
  logic [7:0]                     cnt_q, cnt_d;

  assign sel_ok = (int'(selecao) < N_DEST);
  assign sel_oh = N_DEST'(1) << selecao;
  // Out-of-range codes must never reach a lane, so the enable is range-gated
  assign acc    = escreve && sel_ok;
  assign we_vec = acc ? sel_oh : '0;

  for (genvar k = 0; k < N_DEST; k++) begin : g_lane
    demux12_lane #(.W(LARGURA)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (limpa),
      .we_i  (we_vec[k]),
      .d_i   (entrada),
      .q_o   (dest_q[k])
    );
  end

  always_comb begin
    pulso_d  = '0;
    ultimo_d = ultimo_q;
    erro_d   = erro_q;
    cnt_d    = cnt_q;
    if (limpa) begin
      ultimo_d = '0;
      erro_d   = 1'b0;
      cnt_d    = '0;
    end else if (escreve) begin
      if (sel_ok) begin
        pulso_d  = sel_oh;
        ultimo_d = selecao;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else begin
        erro_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulso_q  <= '0;
      ultimo_q <= '0;
      erro_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pulso_q  <= pulso_d;
      ultimo_q <= ultimo_d;
      erro_q   <= erro_d;
      cnt_q    <= cnt_d;
    end
  end

  assign primeiro = dest_q[0];
  assign segundo  = dest_q[1];
  assign terceiro = dest_q[2];
  assign quarto   = dest_q[3];
  assign quinto   = dest_q[4];
  assign sexto    = dest_q[5];
  assign setimo   = dest_q[6];
  assign oitavo   = dest_q[7];
  assign nono     = dest_q[8];
  assign decimo   = dest_q[9];
  assign onze     = dest_q[10];
  assign doze     = dest_q[11];
  assign pulso    = pulso_q;
  assign ultimo   = ultimo_q;
  assign erro     = erro_q;
  assign contagem = cnt_q;
endmodule
